uart_rx_oversample: RTL

//  UART 8N1 receiver; the receive end of the UART_System serial link (pairs with the

---
 rtl/uart_rx_oversample.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_oversample.sv
// rtl/uart_rx_oversample.sv - UART 8N1 receiver with 3-sample majority vote and valid/ready output
module uart_rx_oversample #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_en,
    input  logic       rx_line,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int MID = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] CNT_MIDM1 = CW'(MID - 1);
    localparam logic [CW-1:0] CNT_MID   = CW'(MID);
    localparam logic [CW-1:0] CNT_MIDP1 = CW'(MID + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d;
    logic          rx_s_q, rx_s_d;
    logic          rx_prev_q, rx_prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    samp_q, samp_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          busy_q, busy_d;

    logic          vote;
    logic          at_vote;
    logic          cnt_last;
    logic          deliver;

    // The third vote sample is the live synchronised line at MID+1.
    assign vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
    assign at_vote  = (cnt_q == CNT_MIDP1);
    assign cnt_last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        sync1_d     = rx_line;
        rx_s_d      = sync1_q;
        rx_prev_d   = rx_s_q;
        cnt_d       = cnt_last ? '0 : cnt_q + 1'b1;
        samp_d      = samp_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver     = 1'b0;

        if (cnt_q == CNT_MIDM1) samp_d[0] = rx_s_q;
        if (cnt_q == CNT_MID)   samp_d[1] = rx_s_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rx_en && rx_prev_q && !rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (at_vote && vote) begin
                    state_d = S_IDLE;
                end else if (cnt_last) begin
                    state_d = S_DATA;
                    idx_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (at_vote) shift_d[idx_q] = vote;
                if (cnt_last) begin
                    if (idx_q == 3'd7) state_d = S_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            S_STOP: begin
                // Leave at mid-stop so the next start edge is caught with margin.
                if (at_vote) begin
                    state_d = S_IDLE;
                    if (vote) deliver     = 1'b1;
                    else      frame_err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && !rx_en) begin
            state_d     = S_IDLE;
            deliver     = 1'b0;
            frame_err_d = 1'b0;
        end

        if (deliver) begin
            if (!rx_valid_q) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else if (rx_ready) begin
                rx_data_d  = shift_q;
            end else begin
                overrun_d  = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            cnt_q       <= '0;
            samp_q      <= 2'b00;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            rx_s_q      <= rx_s_d;
            rx_prev_q   <= rx_prev_d;
            cnt_q       <= cnt_d;
            samp_q      <= samp_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule
